// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed scan controller for an NDIG-digit common-anode
//   7-segment display. Each digit gets a blanking gap (BLANK_CYC cycles,
//   all anodes off) followed by a lit slot (DIV cycles). New display data
//   is staged in a shadow register and committed only at the frame wrap.
//   Optional feature: define SEG7_LZB_EN to enable leading-zero blanking.
//   All outputs are registered and track the current FSM state.
module seg7_scan_ctrl #(
   parameter int NDIG      = 8,
   parameter int DIV       = 100000,
   parameter int BLANK_CYC = 1000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*NDIG-1:0]   iData,
   input  logic                iLoad,
   input  logic [NDIG-1:0]     iEnMask,
   output logic [3:0]          oDigit,
   output logic [NDIG-1:0]     oAnode,
   output logic                oFrame
);

   localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                wrap_s;
   logic [4*NDIG-1:0]   active_q, active_d;
   logic [4*NDIG-1:0]   shadow_q, shadow_d;
   logic                pending_q, pending_d;
   logic [3:0]          digit_q, digit_d;
   logic [NDIG-1:0]     anode_q, anode_d;
   logic                frame_q;
   logic [NDIG-1:0]     lzb_s;

   // Select the nibble belonging to digit k.
   function automatic logic [3:0] nibble_at(input logic [4*NDIG-1:0] a,
                                            input logic [IW-1:0]     k);
      nibble_at = 4'd0;
      for (int j = 0; j < NDIG; j++) begin
         nibble_at = (k == IW'(j)) ? a[4*j +: 4] : nibble_at;
      end
   endfunction

`ifdef SEG7_LZB_EN
   // Digit k>0 is a leading zero when it and every higher digit are zero.
   function automatic logic [NDIG-1:0] lzb_mask(input logic [4*NDIG-1:0] a);
      logic all_zero;
      lzb_mask = '0;
      all_zero = 1'b1;
      for (int k = NDIG - 1; k >= 0; k--) begin
         all_zero    = all_zero && (a[4*k +: 4] == 4'd0);
         lzb_mask[k] = all_zero && (k > 0);
      end
   endfunction

   assign lzb_s = lzb_mask(active_d);
`else
   assign lzb_s = '0;
`endif

   // Scan FSM: BLANK/SHOW sequencing, dwell counter and digit index.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      idx_d   = idx_q;
      wrap_s  = 1'b0;
      case (state_q)
         ST_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = ST_SHOW;
               cnt_d   = '0;
            end else begin
               state_d = ST_BLANK;
            end
         end
         ST_SHOW: begin
            if (cnt_q == DIV_LAST) begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d  = '0;
                  wrap_s = 1'b1;
               end else begin
                  idx_d  = idx_q + IW'(1);
               end
            end else begin
               state_d = ST_SHOW;
            end
         end
         default: begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   // Load path: stage into shadow, commit at the wrap (a load on the wrap bypasses shadow).
   always_comb begin
      shadow_d  = shadow_q;
      pending_d = pending_q;
      active_d  = active_q;
      if (wrap_s) begin
         if (iLoad) begin
            active_d  = iData;
            pending_d = 1'b0;
         end else if (pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
         end else begin
            active_d  = active_q;
         end
      end else if (iLoad) begin
         shadow_d  = iData;
         pending_d = 1'b1;
      end else begin
         shadow_d  = shadow_q;
      end
   end

   // Output decode from next state so registered outputs line up with the state register.
   always_comb begin
      anode_d = '1;
      digit_d = nibble_at(active_d, idx_d);
      if (state_d == ST_SHOW) begin
         for (int j = 0; j < NDIG; j++) begin
            anode_d[j] = !((idx_d == IW'(j)) && iEnMask[j] &&
                           (active_d[4*j +: 4] <= 4'd9) && !lzb_s[j]);
         end
      end else begin
         anode_d = '1;
      end
   end

   // State, data and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_BLANK;
         cnt_q     <= '0;
         idx_q     <= '0;
         active_q  <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         digit_q   <= 4'd0;
         anode_q   <= '1;
         frame_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         digit_q   <= digit_d;
         anode_q   <= anode_d;
         frame_q   <= wrap_s;
      end
   end

   assign oDigit = digit_q;
   assign oAnode = anode_q;
   assign oFrame = frame_q;

endmodule
